// File: rtl/divu16_nonrestoring.sv
// Sequential unsigned divider, radix-2 non-restoring. One quotient bit per clock
// through a single (WIDTH+1)-bit add/subtract datapath, start/busy/ready handshake.
module divu16_nonrestoring #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         r,
    output logic                     busy,
    output logic                     ready,
    output logic                     dz,
    output logic [$clog2(WIDTH)-1:0] count
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH:0]     rem_r, rem_s;
    logic [WIDTH-1:0]   qreg_r, qreg_s;
    logic [WIDTH-1:0]   b_r, b_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [WIDTH-1:0]   q_r, q_s;
    logic [WIDTH-1:0]   r_r, r_s;
    logic               busy_r, busy_s;
    logic               ready_r, ready_s;
    logic               dz_r, dz_s;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     step_rem_s;
    logic [WIDTH-1:0]   step_q_s;
    logic [WIDTH:0]     corr_rem_s;
    logic               last_s;

    // One non-restoring step: the sign of the old partial remainder picks add or subtract.
    always_comb begin
        shifted_s = {rem_r[WIDTH-1:0], qreg_r[WIDTH-1]};
        if (rem_r[WIDTH]) begin
            step_rem_s = shifted_s + {1'b0, b_r};
        end else begin
            step_rem_s = shifted_s - {1'b0, b_r};
        end
        step_q_s = {qreg_r[WIDTH-2:0], ~step_rem_s[WIDTH]};
        // A negative final remainder is restored by adding the divisor back once.
        if (step_rem_s[WIDTH]) begin
            corr_rem_s = step_rem_s + {1'b0, b_r};
        end else begin
            corr_rem_s = step_rem_s;
        end
        last_s = (count_r == CNT_W'(WIDTH - 1));
    end

    // Next-state and next-output logic for the accept/iterate/finish sequence.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        qreg_s  = qreg_r;
        b_s     = b_r;
        count_s = count_r;
        q_s     = q_r;
        r_s     = r_r;
        dz_s    = dz_r;
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    qreg_s  = a;
                    rem_s   = {(WIDTH + 1){1'b0}};
                    b_s     = b;
                    dz_s    = (b == {WIDTH{1'b0}});
                    count_s = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_s  = step_rem_s;
                qreg_s = step_q_s;
                if (last_s) begin
                    state_s = ST_IDLE;
                    q_s     = step_q_s;
                    r_s     = corr_rem_s[WIDTH-1:0];
                    ready_s = 1'b1;
                    count_s = {CNT_W{1'b0}};
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_RUN);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= {(WIDTH + 1){1'b0}};
            qreg_r  <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            qreg_r  <= qreg_s;
            b_r     <= b_s;
            count_r <= count_s;
            q_r     <= q_s;
            r_r     <= r_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
            dz_r    <= dz_s;
        end
    end

    assign q     = q_r;
    assign r     = r_r;
    assign busy  = busy_r;
    assign ready = ready_r;
    assign dz    = dz_r;
    assign count = count_r;

endmodule
